// File: rtl/lemming_pkg.sv
// Shared types and constants for the lemming colony controller.
package lemming_pkg;

    typedef enum logic [2:0] {
        ST_WL    = 3'd0,
        ST_WR    = 3'd1,
        ST_FL    = 3'd2,
        ST_FR    = 3'd3,
        ST_DL    = 3'd4,
        ST_DR    = 3'd5,
        ST_SPLAT = 3'd6
    } lane_state_t;

    localparam int FALL_CNT_W = 5;
    localparam logic [FALL_CNT_W-1:0] FALL_CNT_MAX = 5'd31;

endpackage

// File: rtl/lemming_lane.sv
// One lemming walker FSM with its fall-length counter; digging only starts on grant.
module lemming_lane
    import lemming_pkg::*;
#(
    parameter int FALL_LIMIT = 20
) (
    input  logic        clk,
    input  logic        areset,
    input  logic        ground,
    input  logic        bump_left,
    input  logic        bump_right,
    input  logic        dig_req,
    input  logic        grant,
    output logic        walk_left,
    output logic        walk_right,
    output logic        aaah,
    output logic        digging,
    output logic        splat,
    output logic        dig_release,
    output logic        splat_entry,
    output lane_state_t state
);

    lane_state_t state_q, state_d;
    logic [FALL_CNT_W-1:0] fall_cnt, fall_cnt_d;

    always_ff @(posedge clk) begin
        if (areset) begin
            state_q  <= ST_WL;
            fall_cnt <= '0;
        end else begin
            state_q  <= state_d;
            fall_cnt <= fall_cnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        fall_cnt_d  = fall_cnt;
        dig_release = 1'b0;
        splat_entry = 1'b0;
        case (state_q)
            ST_WL: begin
                if (!ground) begin
                    state_d    = ST_FL;
                    fall_cnt_d = '0;
                end else if (grant && dig_req) begin
                    state_d = ST_DL;
                end else if (bump_left || bump_right) begin
                    state_d = ST_WR;
                end
            end
            ST_WR: begin
                if (!ground) begin
                    state_d    = ST_FR;
                    fall_cnt_d = '0;
                end else if (grant && dig_req) begin
                    state_d = ST_DR;
                end else if (bump_left || bump_right) begin
                    state_d = ST_WL;
                end
            end
            ST_DL, ST_DR: begin
                if (!ground) begin
                    state_d     = (state_q == ST_DL) ? ST_FL : ST_FR;
                    fall_cnt_d  = '0;
                    dig_release = 1'b1;
                end
            end
            ST_FL, ST_FR: begin
                if (!ground) begin
                    if (fall_cnt != FALL_CNT_MAX) fall_cnt_d = fall_cnt + FALL_CNT_W'(1);
                end else if (int'(fall_cnt) >= FALL_LIMIT) begin
                    state_d     = ST_SPLAT;
                    splat_entry = 1'b1;
                end else begin
                    state_d = (state_q == ST_FL) ? ST_WL : ST_WR;
                end
            end
            ST_SPLAT: ;
            default: state_d = ST_WL;
        endcase
    end

    assign walk_left  = (state_q == ST_WL);
    assign walk_right = (state_q == ST_WR);
    assign aaah       = (state_q == ST_FL) || (state_q == ST_FR);
    assign digging    = (state_q == ST_DL) || (state_q == ST_DR);
    assign splat      = (state_q == ST_SPLAT);
    assign state      = state_q;

endmodule

// File: rtl/lemming_shovel_arbiter.sv
// N lemming lanes sharing one shovel through a round-robin grant; owner is one-hot.
module lemming_shovel_arbiter
    import lemming_pkg::*;
#(
    parameter int N          = 4,
    parameter int FALL_LIMIT = 20
) (
    input  logic                   clk,
    input  logic                   areset,
    input  logic [N-1:0]           bump_left,
    input  logic [N-1:0]           bump_right,
    input  logic [N-1:0]           ground,
    input  logic [N-1:0]           dig_req,
    output logic [N-1:0]           walk_left,
    output logic [N-1:0]           walk_right,
    output logic [N-1:0]           aaah,
    output logic [N-1:0]           digging,
    output logic [N-1:0]           splat,
    output logic [N-1:0]           owner,
    output logic [$clog2(N+1)-1:0] alive_count
);

    localparam int PTR_W = $clog2(N);
    localparam int CNT_W = $clog2(N+1);

    logic [PTR_W-1:0] rr_ptr, rr_ptr_d;
    logic [N-1:0]     eligible, grant, dig_release, splat_entry;
    lane_state_t      lane_state [N];

    for (genvar i = 0; i < N; i++) begin : g_lane
        lemming_lane #(.FALL_LIMIT(FALL_LIMIT)) u_lane (
            .clk         (clk),
            .areset      (areset),
            .ground      (ground[i]),
            .bump_left   (bump_left[i]),
            .bump_right  (bump_right[i]),
            .dig_req     (dig_req[i]),
            .grant       (grant[i]),
            .walk_left   (walk_left[i]),
            .walk_right  (walk_right[i]),
            .aaah        (aaah[i]),
            .digging     (digging[i]),
            .splat       (splat[i]),
            .dig_release (dig_release[i]),
            .splat_entry (splat_entry[i]),
            .state       (lane_state[i])
        );

        // Only a free shovel can be granted, so release and grant never share an edge.
        assign eligible[i] = ((lane_state[i] == ST_WL) || (lane_state[i] == ST_WR))
                             && ground[i] && dig_req[i] && (owner == '0);
    end

    always_comb begin
        int   idx;
        logic found;
        grant    = '0;
        rr_ptr_d = rr_ptr;
        found    = 1'b0;
        idx      = 0;
        for (int k = 0; k < N; k++) begin
            idx = int'(rr_ptr) + k;
            if (idx >= N) idx = idx - N;
            if (!found && eligible[idx]) begin
                found       = 1'b1;
                grant[idx]  = 1'b1;
                rr_ptr_d    = (idx == N-1) ? '0 : PTR_W'(idx + 1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (areset) begin
            owner       <= '0;
            rr_ptr      <= '0;
            alive_count <= CNT_W'(N);
        end else begin
            if (|grant) begin
                owner  <= grant;
                rr_ptr <= rr_ptr_d;
            end else if (|(owner & dig_release)) begin
                owner <= '0;
            end
            alive_count <= alive_count - CNT_W'($countones(splat_entry));
        end
    end

endmodule

// File: tb/tb_lemming_shovel_arbiter.sv
// Bench for lemming_shovel_arbiter: directed scenarios plus random traffic against a lane-activity model.
module tb_lemming_shovel_arbiter;

    localparam int N          = 4;
    localparam int FALL_LIMIT = 20;
    localparam int CNT_W      = $clog2(N+1);
    localparam logic [N-1:0] F = '1;
    localparam logic [N-1:0] Z = '0;

    // Model activity codes
    localparam int M_WALK = 0;
    localparam int M_FALL = 1;
    localparam int M_DIG  = 2;
    localparam int M_DEAD = 3;

    logic             clk = 1'b0;
    logic             areset;
    logic [N-1:0]     bump_left, bump_right, ground, dig_req;
    logic [N-1:0]     walk_left, walk_right, aaah, digging, splat, owner;
    logic [CNT_W-1:0] alive_count;

    always #5 clk = ~clk;

    lemming_shovel_arbiter #(.N(N), .FALL_LIMIT(FALL_LIMIT)) dut (
        .clk         (clk),
        .areset      (areset),
        .bump_left   (bump_left),
        .bump_right  (bump_right),
        .ground      (ground),
        .dig_req     (dig_req),
        .walk_left   (walk_left),
        .walk_right  (walk_right),
        .aaah        (aaah),
        .digging     (digging),
        .splat       (splat),
        .owner       (owner),
        .alive_count (alive_count)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    int m_act  [N];
    int m_dir  [N];
    int m_fall [N];
    int m_owner;
    int m_rr;

    task automatic model_step(input logic [N-1:0] g, input logic [N-1:0] bl, input logic [N-1:0] br,
                              input logic [N-1:0] rq, input logic rst);
        int win;
        if (rst) begin
            for (int i = 0; i < N; i++) begin
                m_act[i]  = M_WALK;
                m_dir[i]  = 0;
                m_fall[i] = 0;
            end
            m_owner = -1;
            m_rr    = 0;
            return;
        end
        win = -1;
        if (m_owner < 0) begin
            for (int k = 0; k < N; k++) begin
                int idx;
                idx = (m_rr + k) % N;
                if (win < 0 && m_act[idx] == M_WALK && g[idx] && rq[idx]) win = idx;
            end
        end
        for (int i = 0; i < N; i++) begin
            case (m_act[i])
                M_WALK: begin
                    if (!g[i]) begin
                        m_act[i]  = M_FALL;
                        m_fall[i] = 0;
                    end else if (i == win) begin
                        m_act[i] = M_DIG;
                    end else if (bl[i] || br[i]) begin
                        m_dir[i] = 1 - m_dir[i];
                    end
                end
                M_DIG: begin
                    if (!g[i]) begin
                        m_act[i]  = M_FALL;
                        m_fall[i] = 0;
                        if (m_owner == i) m_owner = -1;
                    end
                end
                M_FALL: begin
                    if (!g[i]) m_fall[i] = (m_fall[i] < 31) ? m_fall[i] + 1 : 31;
                    else if (m_fall[i] >= FALL_LIMIT) m_act[i] = M_DEAD;
                    else m_act[i] = M_WALK;
                end
                default: ;
            endcase
        end
        if (win >= 0) begin
            m_owner = win;
            m_rr    = (win + 1) % N;
        end
    endtask

    function automatic logic [N-1:0] act_mask(input int act, input int dir);
        logic [N-1:0] v;
        v = '0;
        for (int i = 0; i < N; i++)
            if (m_act[i] == act && (dir < 0 || m_dir[i] == dir)) v[i] = 1'b1;
        return v;
    endfunction

    task automatic check_all(input string tag);
        logic [N-1:0] own_e;
        int alive_e;
        own_e = '0;
        if (m_owner >= 0) own_e[m_owner] = 1'b1;
        alive_e = 0;
        for (int i = 0; i < N; i++) if (m_act[i] != M_DEAD) alive_e++;
        check({tag, ".walk_left"},  walk_left,  act_mask(M_WALK, 0));
        check({tag, ".walk_right"}, walk_right, act_mask(M_WALK, 1));
        check({tag, ".aaah"},       aaah,       act_mask(M_FALL, -1));
        check({tag, ".digging"},    digging,    act_mask(M_DIG, -1));
        check({tag, ".splat"},      splat,      act_mask(M_DEAD, -1));
        check({tag, ".owner"},      owner,      own_e);
        check({tag, ".alive"},      alive_count, alive_e);
    endtask

    task automatic step(input logic [N-1:0] g, input logic [N-1:0] bl, input logic [N-1:0] br,
                        input logic [N-1:0] rq, input logic rst, input string tag);
        areset     = rst;
        ground     = g;
        bump_left  = bl;
        bump_right = br;
        dig_req    = rq;
        @(posedge clk);
        model_step(g, bl, br, rq, rst);
        #1;
        check_all(tag);
    endtask

    int low_run [N];

    initial begin
        logic [N-1:0] exp_own, g, bl, br, rq;
        logic         rst;

        // Reset and idle
        step(F, Z, Z, Z, 1'b1, "reset");
        check("reset_fall_cnt0", dut.g_lane[0].u_lane.fall_cnt, 0);
        repeat (5) step(F, Z, Z, Z, 1'b0, "idle");
        check("idle_walk_left", walk_left, 4'b1111);
        check("idle_owner", owner, 4'b0000);
        check("idle_alive", alive_count, 4);

        // Two simultaneous requests, then owner falls and shovel moves on
        step(F, Z, Z, 4'b0101, 1'b0, "req02");
        check("req02_owner", owner, 4'b0001);
        check("req02_digging", digging, 4'b0001);
        check("req02_lane2_walks", walk_left[2], 1'b1);
        step(4'b1110, Z, Z, 4'b0101, 1'b0, "drop0");
        check("drop0_aaah0", aaah[0], 1'b1);
        check("drop0_owner", owner, 4'b0000);
        step(F, Z, Z, 4'b0101, 1'b0, "regrant");
        check("regrant_owner", owner, 4'b0100);

        // Fall length boundary on lane 1
        step(F, Z, Z, Z, 1'b1, "reset2");
        repeat (20) step(4'b1101, Z, Z, Z, 1'b0, "fall20");
        step(F, Z, Z, Z, 1'b0, "land20");
        check("land20_walk_left1", walk_left[1], 1'b1);
        check("land20_splat1", splat[1], 1'b0);
        repeat (21) step(4'b1101, Z, Z, Z, 1'b0, "fall21");
        step(F, Z, Z, Z, 1'b0, "land21");
        check("land21_splat1", splat[1], 1'b1);
        check("land21_alive", alive_count, 3);
        repeat (3) step(F, 4'b0010, 4'b0010, 4'b0010, 1'b0, "dead_ignores");
        check("dead_owner", owner, 4'b0000);
        check("dead_splat1", splat[1], 1'b1);

        // Lane 3: double bump reverses, dig beats bump, bumps ignored while digging
        step(F, Z, Z, Z, 1'b1, "reset3");
        step(F, 4'b1000, 4'b1000, Z, 1'b0, "bump3");
        check("bump3_walk_right", walk_right[3], 1'b1);
        step(F, 4'b1000, 4'b1000, 4'b1000, 1'b0, "digbump3");
        check("digbump3_digging", digging, 4'b1000);
        check("digbump3_owner", owner, 4'b1000);
        repeat (3) step(F, 4'b1000, 4'b1000, 4'b1000, 1'b0, "dig_hold3");
        check("dig_hold3_digging", digging[3], 1'b1);

        // Fairness: all request, each owner forced to fall in turn
        step(F, Z, Z, Z, 1'b1, "reset4");
        for (int k = 0; k < N; k++) begin
            int waited;
            waited = 0;
            step(F, Z, Z, F, 1'b0, "fair_req");
            while (owner == '0 && waited < 8) begin
                step(F, Z, Z, F, 1'b0, "fair_wait");
                waited++;
            end
            exp_own    = '0;
            exp_own[k] = 1'b1;
            check("fair_order", owner, exp_own);
            step(~owner, Z, Z, F, 1'b0, "fair_drop");
        end

        // Reset while lane 2 digs and lane 0 falls
        step(F, Z, Z, Z, 1'b1, "reset5");
        step(F, Z, Z, 4'b0100, 1'b0, "dig2");
        step(4'b1110, Z, Z, 4'b0100, 1'b0, "fall0a");
        step(4'b1110, Z, Z, 4'b0100, 1'b0, "fall0b");
        step(4'b1110, Z, Z, 4'b0100, 1'b1, "abort");
        check("abort_walk_left", walk_left, 4'b1111);
        check("abort_owner", owner, 4'b0000);
        check("abort_alive", alive_count, 4);
        check("abort_fall_cnt0", dut.g_lane[0].u_lane.fall_cnt, 0);

        // Random traffic with occasional long ground gaps
        for (int i = 0; i < N; i++) low_run[i] = 0;
        repeat (1500) begin
            for (int i = 0; i < N; i++) begin
                if (low_run[i] == 0 && $urandom_range(0, 39) == 0) low_run[i] = $urandom_range(1, 26);
                g[i] = (low_run[i] == 0);
                if (low_run[i] > 0) low_run[i]--;
                bl[i] = ($urandom_range(0, 3) == 0);
                br[i] = ($urandom_range(0, 3) == 0);
                rq[i] = ($urandom_range(0, 1) == 0);
            end
            rst = ($urandom_range(0, 299) == 0);
            step(g, bl, br, rq, rst, "rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
